// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the timer controller: FSM state encoding and mode values.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale divider: emits one tick every div+1 enabled cycles; clr restarts the phase.
module timer_prescaler #(
  parameter int PS_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr,
  input  logic [PS_WIDTH-1:0] div,
  output logic                tick
);

  logic [PS_WIDTH-1:0] ps_cnt_q;
  logic [PS_WIDTH-1:0] ps_cnt_d;
  logic                wrap;

  always_comb begin
    wrap     = (ps_cnt_q == div);
    tick     = en && wrap;
    ps_cnt_d = ps_cnt_q;
    if (clr) begin
      ps_cnt_d = '0;
    end else if (en) begin
      ps_cnt_d = wrap ? '0 : ps_cnt_q + PS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt_q <= '0;
    end else begin
      ps_cnt_q <= ps_cnt_d;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Timer sequencing controller: start/stop/pause FSM, prescaled counter, terminal-count match and sticky irq.
// Optional capture port set enabled by defining TIMER_CTRL_CAPTURE_EN.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int PS_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic [PS_WIDTH-1:0] cfg_prescale,
  input  logic                cfg_mode,
  input  logic                start,
  input  logic                stop,
  input  logic                hold,
  input  logic                irq_ack,
  output logic                busy,
  output logic [WIDTH-1:0]    count,
  output logic                done_pulse,
  output logic                irq,
  output logic                overrun,
`ifdef TIMER_CTRL_CAPTURE_EN
  input  logic                capture_in,
  output logic [WIDTH-1:0]    capture_val,
  output logic                capture_valid,
`endif
  output logic [1:0]          dbg_state
);

  state_e               state_q;
  logic [WIDTH-1:0]     count_q;
  logic [WIDTH-1:0]     period_q;
  logic [PS_WIDTH-1:0]  prescale_q;
  logic                 mode_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 irq_q;
  logic                 ovr_q;

  logic ps_en;
  logic ps_clr;
  logic tick;
  logic match;

  // Counting happens on every busy cycle without hold; stop suppresses the tick so it beats any match.
  assign ps_en  = (state_q != IDLE) && !stop && !hold;
  assign ps_clr = (state_q == IDLE) && start && !stop;
  assign match  = tick && (count_q == period_q);

  timer_prescaler #(
    .PS_WIDTH(PS_WIDTH)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (ps_en),
    .clr  (ps_clr),
    .div  (prescale_q),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      period_q   <= '0;
      prescale_q <= '0;
      mode_q     <= MODE_ONESHOT;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      done_q <= match;
      // A match sets irq even when acked in the same cycle; overrun needs irq already pending.
      if (match) begin
        irq_q <= 1'b1;
        if (irq_q) begin
          ovr_q <= 1'b1;
        end else if (irq_ack) begin
          ovr_q <= 1'b0;
        end
      end else if (irq_ack) begin
        irq_q <= 1'b0;
        ovr_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (cfg_we) begin
            period_q   <= cfg_period;
            prescale_q <= cfg_prescale;
            mode_q     <= cfg_mode;
          end
          if (start && !stop) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            count_q <= '0;
          end
        end
        RUN, PAUSE: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (match && (mode_q == MODE_ONESHOT)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= hold ? PAUSE : RUN;
            if (match) begin
              count_q <= '0;
            end else if (tick) begin
              count_q <= count_q + WIDTH'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign count      = count_q;
  assign done_pulse = done_q;
  assign irq        = irq_q;
  assign overrun    = ovr_q;
  assign dbg_state  = state_q;

`ifdef TIMER_CTRL_CAPTURE_EN
  logic             cap_prev_q;
  logic [WIDTH-1:0] cap_val_q;
  logic             cap_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_prev_q  <= 1'b0;
      cap_val_q   <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      cap_prev_q  <= capture_in;
      cap_valid_q <= 1'b0;
      if (capture_in && !cap_prev_q && (state_q != IDLE)) begin
        cap_val_q   <= count_q;
        cap_valid_q <= 1'b1;
      end
    end
  end

  assign capture_val   = cap_val_q;
  assign capture_valid = cap_valid_q;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: tick-count reference model checked every cycle, directed scenarios, random phase.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [31:0] cfg_period = '0;
  logic [7:0]  cfg_prescale = '0;
  logic        cfg_mode = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        hold = 1'b0;
  logic        irq_ack = 1'b0;
  logic        busy;
  logic [31:0] count;
  logic        done_pulse;
  logic        irq;
  logic        overrun;
  logic [1:0]  dbg_state;
`ifdef TIMER_CTRL_CAPTURE_EN
  logic        capture_in = 1'b0;
  logic [31:0] capture_val;
  logic        capture_valid;
`endif

  int checks = 0;
  int errors = 0;

  timer_ctrl #(.WIDTH(32), .PS_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_period  (cfg_period),
    .cfg_prescale(cfg_prescale),
    .cfg_mode    (cfg_mode),
    .start       (start),
    .stop        (stop),
    .hold        (hold),
    .irq_ack     (irq_ack),
    .busy        (busy),
    .count       (count),
    .done_pulse  (done_pulse),
    .irq         (irq),
    .overrun     (overrun),
`ifdef TIMER_CTRL_CAPTURE_EN
    .capture_in   (capture_in),
    .capture_val  (capture_val),
    .capture_valid(capture_valid),
`endif
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: tracks counting cycles n and ticks t since the last start.
  logic   m_busy = 1'b0;
  longint m_count = 0;
  longint m_n = 0;
  longint m_t = 0;
  longint s_period = 0;
  longint s_ps = 0;
  logic   s_mode = 1'b0;
  logic   m_irq = 1'b0;
  logic   m_ovr = 1'b0;
  logic   m_done = 1'b0;
  logic   m_match = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_count = 0; m_n = 0; m_t = 0;
      s_period = 0; s_ps = 0; s_mode = 0;
      m_irq = 0; m_ovr = 0; m_done = 0;
    end else begin
      m_match = 1'b0;
      if (!m_busy) begin
        if (cfg_we) begin
          s_period = longint'(cfg_period);
          s_ps     = longint'(cfg_prescale);
          s_mode   = cfg_mode;
        end
        if (start && !stop) begin
          m_busy = 1; m_n = 0; m_t = 0; m_count = 0;
        end
      end else if (stop) begin
        m_busy = 0;
      end else if (!hold) begin
        m_n++;
        if (m_n % (s_ps + 1) == 0) begin
          m_t++;
          if (m_t % (s_period + 1) == 0) begin
            m_match = 1'b1;
            if (s_mode) m_count = 0;
            else begin
              m_count = s_period;
              m_busy  = 0;
            end
          end else begin
            m_count = m_t % (s_period + 1);
          end
        end
      end
      if (m_match) begin
        if (m_irq) m_ovr = 1;
        else if (irq_ack) m_ovr = 0;
        m_irq = 1;
      end else if (irq_ack) begin
        m_irq = 0;
        m_ovr = 0;
      end
      m_done = m_match;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard compare on every falling edge
  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_busy));
    chk("count", 64'(count), 64'(m_count));
    chk("done_pulse", 64'(done_pulse), 64'(m_done));
    chk("irq", 64'(irq), 64'(m_irq));
    chk("overrun", 64'(overrun), 64'(m_ovr));
  end

  // Driver tasks
  task automatic tick_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cfg_we = 0; start = 0; stop = 0; hold = 0; irq_ack = 0;
`ifdef TIMER_CTRL_CAPTURE_EN
    capture_in = 0;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick_cyc();
    tick_cyc();
    rst_n = 1;
  endtask

  task automatic run_cfg(input logic [31:0] p, input logic [7:0] ps, input logic md);
    cfg_we = 1; cfg_period = p; cfg_prescale = ps; cfg_mode = md; start = 1;
    tick_cyc();
    cfg_we = 0; start = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);

    // Auto-reload, period 3, no prescale
    run_cfg(32'd3, 8'd0, 1'b1);
    chk("t1_start_count", 64'(count), 64'd0);
    chk("t1_start_busy", 64'(busy), 64'd1);
    repeat (3) tick_cyc();
    chk("t1_count3", 64'(count), 64'd3);
    tick_cyc();
    chk("t1_wrap", 64'(count), 64'd0);
    chk("t1_done", 64'(done_pulse), 64'd1);
    chk("t1_irq", 64'(irq), 64'd1);
    tick_cyc();
    chk("t1_count1", 64'(count), 64'd1);

    // One-shot, period 2, prescale 3: match 12 cycles after start
    do_reset();
    run_cfg(32'd2, 8'd3, 1'b0);
    repeat (11) tick_cyc();
    chk("t2_before_busy", 64'(busy), 64'd1);
    tick_cyc();
    chk("t2_busy", 64'(busy), 64'd0);
    chk("t2_count", 64'(count), 64'd2);
    chk("t2_done", 64'(done_pulse), 64'd1);
    repeat (6) tick_cyc();

    // Overrun and acknowledge interplay
    do_reset();
    run_cfg(32'd1, 8'd0, 1'b1);
    repeat (4) tick_cyc();
    chk("t3_overrun", 64'(overrun), 64'd1);
    irq_ack = 1;
    tick_cyc();
    chk("t3_ack_irq", 64'(irq), 64'd0);
    chk("t3_ack_ovr", 64'(overrun), 64'd0);
    tick_cyc();
    irq_ack = 0;
    chk("t3_coinc_irq", 64'(irq), 64'd1);
    chk("t3_coinc_ovr", 64'(overrun), 64'd0);

    // Pause and resume
    do_reset();
    run_cfg(32'd100, 8'd0, 1'b1);
    repeat (5) tick_cyc();
    chk("t4_count5", 64'(count), 64'd5);
    hold = 1;
    repeat (10) tick_cyc();
    chk("t4_held", 64'(count), 64'd5);
    chk("t4_state", 64'(dbg_state), 64'd2);
    chk("t4_busy", 64'(busy), 64'd1);
    hold = 0;
    tick_cyc();
    chk("t4_resume", 64'(count), 64'd6);

    // Ignored config write, then stop beating start and a match tick
    do_reset();
    run_cfg(32'd7, 8'd0, 1'b1);
    repeat (3) tick_cyc();
    cfg_we = 1; cfg_period = 32'd9;
    tick_cyc();
    cfg_we = 0;
    repeat (3) tick_cyc();
    chk("t5_count7", 64'(count), 64'd7);
    stop = 1; start = 1;
    tick_cyc();
    stop = 0; start = 0;
    chk("t5_stop_busy", 64'(busy), 64'd0);
    chk("t5_stop_count", 64'(count), 64'd7);
    chk("t5_stop_done", 64'(done_pulse), 64'd0);
    start = 1;
    tick_cyc();
    start = 0;
    repeat (8) tick_cyc();
    chk("t5_old_period", 64'(count), 64'd0);
    chk("t5_old_done", 64'(done_pulse), 64'd1);

    // Asynchronous reset mid-run
    do_reset();
    run_cfg(32'd2, 8'd0, 1'b1);
    repeat (5) tick_cyc();
    chk("t6_irq_set", 64'(irq), 64'd1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_irq", 64'(irq), 64'd0);
    tick_cyc();
    rst_n = 1;

`ifdef TIMER_CTRL_CAPTURE_EN
    do_reset();
    run_cfg(32'd20, 8'd0, 1'b1);
    repeat (4) tick_cyc();
    capture_in = 1;
    tick_cyc();
    chk("cap_val", 64'(capture_val), 64'd4);
    chk("cap_valid", 64'(capture_valid), 64'd1);
    tick_cyc();
    chk("cap_pulse_end", 64'(capture_valid), 64'd0);
    capture_in = 0;
`endif

    // All-ones period counts normally
    do_reset();
    run_cfg(32'hFFFF_FFFF, 8'd0, 1'b0);
    repeat (5) tick_cyc();
    chk("t7_allones", 64'(count), 64'd5);

    // Random phase
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cfg_we       = ($urandom_range(0, 7) == 0);
      cfg_period   = 32'($urandom_range(0, 6));
      cfg_prescale = 8'($urandom_range(0, 3));
      cfg_mode     = 1'($urandom_range(0, 1));
      start        = ($urandom_range(0, 3) == 0);
      stop         = ($urandom_range(0, 39) == 0);
      hold         = ($urandom_range(0, 5) == 0);
      irq_ack      = ($urandom_range(0, 9) == 0);
      tick_cyc();
    end
    clear_inputs();
    tick_cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
